// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button event classifier.
`timescale 1ns/100ps
package btn_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_WAIT2  = 3'd2,
      S_PRESS2 = 3'd3,
      S_HELD   = 3'd4
   } btn_state_t;

   localparam int DEF_LONG_CYC    = 1_000_000;
   localparam int DEF_DBL_GAP_CYC = 250_000;
   localparam int DEF_REPEAT_CYC  = 200_000;

   // Counter width sized by the largest of the three cycle parameters.
   function automatic int btn_cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/btn_cycle_timer.sv
// Loadable saturating up-counter with a terminal-count compare flag.
`timescale 1ns/100ps
module btn_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load wins over increment; increment stops at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/btn_event_classifier.sv
// Classifies a debounced button into short, double and long presses.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
`timescale 1ns/100ps
module btn_event_classifier
   import btn_pkg::*;
#(
   parameter int LONG_CYC    = DEF_LONG_CYC,
   parameter int DBL_GAP_CYC = DEF_DBL_GAP_CYC,
   parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_short,
   output logic o_double,
   output logic o_long,
   output logic o_held,
   output logic o_repeat
);

   localparam int CW = btn_cnt_width(LONG_CYC, DBL_GAP_CYC, REPEAT_CYC);
   // The state-entry sample is the first of a run, so the count trails by one.
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 2);
   localparam logic [CW-1:0] GAP_LAST  = CW'(DBL_GAP_CYC - 2);

   btn_state_t state_q;
   btn_state_t state_d;
   logic short_q, double_q, long_q, held_q;
   logic short_d, double_d, long_d;
   logic cnt_load, cnt_inc, cnt_tc;
   logic [CW-1:0] cnt_tc_val;

   assign cnt_tc_val = (state_q == S_WAIT2) ? GAP_LAST : LONG_LAST;

   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_btn) state_d = S_PRESS1;
         end
         S_PRESS1: begin
            if (!i_btn) begin
               state_d = S_WAIT2;
            end else if (cnt_tc) begin
               state_d = S_HELD;
               long_d  = 1'b1;
            end
         end
         S_WAIT2: begin
            if (i_btn) begin
               state_d = S_PRESS2;
            end else if (cnt_tc) begin
               state_d = S_IDLE;
               short_d = 1'b1;
            end
         end
         S_PRESS2: begin
            if (!i_btn) begin
               state_d  = S_IDLE;
               double_d = 1'b1;
            end else if (cnt_tc) begin
               state_d = S_HELD;
               long_d  = 1'b1;
            end
         end
         S_HELD: begin
            if (!i_btn) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cnt_load = (state_d != state_q);
   assign cnt_inc  = !cnt_load &&
                     ((state_q == S_PRESS1) || (state_q == S_WAIT2) || (state_q == S_PRESS2));

   btn_cycle_timer #(.W(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i ('0),
      .inc_i      (cnt_inc),
      .tc_val_i   (cnt_tc_val),
      .tc_o       (cnt_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         held_q   <= (state_d == S_HELD);
      end
   end

   assign o_short  = short_q;
   assign o_double = double_q;
   assign o_long   = long_q;
   assign o_held   = held_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);

   logic held_stay, rep_tc, rep_load, repeat_d, repeat_q;

   // Restarts on HELD entry and after each pulse; a release sample never pulses.
   assign held_stay = (state_q == S_HELD) && (state_d == S_HELD);
   assign repeat_d  = held_stay && rep_tc;
   assign rep_load  = ((state_d == S_HELD) && (state_q != S_HELD)) || repeat_d;

   btn_cycle_timer #(.W(CW)) u_rep (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rep_load),
      .load_val_i ('0),
      .inc_i      (held_stay),
      .tc_val_i   (REP_LAST),
      .tc_o       (rep_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= repeat_d;
      end
   end

   assign o_repeat = repeat_q;
`else
   assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_classifier.sv
// Randomised and directed bench for btn_event_classifier against a run-length model.
`timescale 1ns/100ps
module tb_btn_event_classifier;

   localparam int LONG = 8;
   localparam int GAP  = 6;
   localparam int REP  = 4;
   localparam int MAXN = 512;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_btn = 1'b0;
   logic o_short, o_double, o_long, o_held, o_repeat;

   int tests = 0;
   int fails = 0;

   int   run_len[$];
   bit   run_hi[$];
   bit   stim[MAXN];
   logic [4:0] expv[MAXN];
   int   nsamp;

   btn_event_classifier #(
      .LONG_CYC    (LONG),
      .DBL_GAP_CYC (GAP),
      .REPEAT_CYC  (REP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (i_btn),
      .o_short  (o_short),
      .o_double (o_double),
      .o_long   (o_long),
      .o_held   (o_held),
      .o_repeat (o_repeat)
   );

   always #1 clk = ~clk;

   function automatic logic [4:0] obs();
      return {o_short, o_double, o_long, o_held, o_repeat};
   endfunction

   task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed={s,d,l,h,r}=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic mark(input int idx, input int bitpos);
      if (idx < nsamp) expv[idx][bitpos] = 1'b1;
   endtask

   task automatic add_run(input bit hi, input int len);
      run_hi.push_back(hi);
      run_len.push_back(len);
   endtask

   // Expected events from whole runs: a sample index t means "visible after edge t".
   task automatic build_model();
      int s;
      int tl;
      bit armed;
      nsamp = 0;
      foreach (run_len[i]) begin
         for (int j = 0; j < run_len[i]; j++) begin
            stim[nsamp] = run_hi[i];
            nsamp++;
         end
      end
      for (int i = 0; i < nsamp; i++) expv[i] = 5'b0;
      s = 0;
      armed = 1'b0;
      foreach (run_len[i]) begin
         if (!run_hi[i]) begin
            if (armed && run_len[i] >= GAP) begin
               mark(s + GAP - 1, 4);
               armed = 1'b0;
            end
         end else if (run_len[i] >= LONG) begin
            tl = s + LONG - 1;
            mark(tl, 2);
            for (int t = tl; t < s + run_len[i]; t++) mark(t, 1);
            if (REP_ON) begin
               for (int k = 1; tl + REP * k <= s + run_len[i] - 1; k++) mark(tl + REP * k, 0);
            end
            armed = 1'b0;
         end else if (armed) begin
            mark(s + run_len[i], 3);
            armed = 1'b0;
         end else begin
            armed = 1'b1;
         end
         s += run_len[i];
      end
   endtask

   task automatic run_scenario(input string name);
      int ev;
      build_model();
      ev = 0;
      for (int t = 0; t < nsamp; t++) begin
         @(negedge clk);
         i_btn = stim[t];
         @(posedge clk);
         #0.5;
         chk($sformatf("%s t=%0d", name, t), obs(), expv[t]);
         ev += int'(expv[t][4]) + int'(expv[t][3]) + int'(expv[t][2]) + int'(expv[t][0]);
      end
      $display("[TB] scenario %s: %0d samples, %0d expected pulses", name, nsamp, ev);
      run_len.delete();
      run_hi.delete();
   endtask

   // Hold reset for a few cycles, check outputs, release between edges.
   task automatic do_reset(input bit lvl);
      rst = 1'b0;
      i_btn = lvl;
      repeat (3) @(posedge clk);
      #0.5;
      chk("reset_hold", obs(), 5'b0);
      rst = 1'b1;
   endtask

   initial begin
      #0.5;
      chk("reset_t0", obs(), 5'b0);
      do_reset(1'b0);

      add_run(0, 2); add_run(1, 3); add_run(0, 10);
      run_scenario("short");

      add_run(0, 1); add_run(1, 3); add_run(0, 2); add_run(1, 3); add_run(0, 10);
      run_scenario("double");

      add_run(0, 1); add_run(1, 20); add_run(0, 10);
      run_scenario("long");

      add_run(0, 1); add_run(1, 3); add_run(0, 2); add_run(1, 3);
      add_run(0, 1); add_run(1, 3); add_run(0, 10);
      run_scenario("dbl_then_short");

      add_run(0, 1); add_run(1, 2); add_run(0, 5); add_run(1, 8); add_run(0, 3);
      add_run(1, 7); add_run(0, 6); add_run(1, 1); add_run(0, 10);
      run_scenario("boundaries");

      do_reset(1'b1);
      add_run(1, 10); add_run(0, 10);
      run_scenario("held_through_reset");

      for (int r = 0; r < 6; r++) begin
         for (int p = 0; p < 8; p++) begin
            int sel;
            add_run(0, int'($urandom_range(1, 9)));
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       add_run(1, int'($urandom_range(1, 5)));
            else if (sel == 2) add_run(1, int'($urandom_range(6, 10)));
            else               add_run(1, int'($urandom_range(11, 22)));
         end
         add_run(0, GAP + 4);
         run_scenario($sformatf("random%0d", r));
      end

      // Reset during the second press must suppress the pending double.
      add_run(0, 1); add_run(1, 3); add_run(0, 2); add_run(1, 2);
      run_scenario("mid_press2");
      #0.2 rst = 1'b0;
      #0.1 chk("async_rst_press2", obs(), 5'b0);
      do_reset(1'b0);
      add_run(0, 20);
      run_scenario("after_rst_press2");

      // Reset while held must drop o_held without waiting for a clock edge.
      add_run(1, 12);
      run_scenario("into_held");
      #0.2 rst = 1'b0;
      #0.1 chk("async_rst_held", obs(), 5'b0);
      do_reset(1'b0);
      add_run(0, 20);
      run_scenario("after_rst_held");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #90000;
      $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
